prog_clock_divider: RTL



---
 rtl/prog_clock_divider.sv | 115 +++++++++++
 1 files changed

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider producing a divided clock, a period tick and
// glitch-free reconfiguration through a shadow register applied only at period boundaries.
module prog_clock_divider #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned OUT_HZ = 128000,
   parameter int unsigned WIDTH  = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             sync,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] div_in,
   input  logic [WIDTH-1:0] high_in,
   output logic             clk_out,
   output logic             tick,
   output logic             cfg_pending
);

   localparam int unsigned DEFAULT_DIV = CLK_HZ / OUT_HZ;
   localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_DIV / 2);
   localparam logic [WIDTH-1:0] MinDiv  = WIDTH'(2);

   if (DEFAULT_DIV < 2 || 64'(DEFAULT_DIV) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_div
      $error("prog_clock_divider: CLK_HZ/OUT_HZ must lie in 2..2**WIDTH-1");
   end

   typedef enum logic {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_act_q, div_act_d;
   logic [WIDTH-1:0] high_act_q, high_act_d;
   logic [WIDTH-1:0] div_sh_q, div_sh_d;
   logic [WIDTH-1:0] high_sh_q, high_sh_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             boundary;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         div_act_q  <= DefDiv;
         high_act_q <= DefHigh;
         div_sh_q   <= DefDiv;
         high_sh_q  <= DefHigh;
         pend_q     <= 1'b0;
         clk_q      <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         high_act_q <= high_act_d;
         div_sh_q   <= div_sh_d;
         high_sh_q  <= high_sh_d;
         pend_q     <= pend_d;
         clk_q      <= clk_d;
         tick_q     <= tick_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      high_act_d = high_act_q;
      div_sh_d   = div_sh_q;
      high_sh_d  = high_sh_q;
      pend_d     = pend_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;
      boundary   = 1'b0;

      if (!enable) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (state_q == StIdle) begin
         state_d  = StRun;
         cnt_d    = '0;
         boundary = 1'b1;
      end else if (sync || (cnt_q == div_act_q - 1'b1)) begin
         cnt_d    = '0;
         boundary = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // Apply uses the shadow as it stood before this cycle's load.
      if (boundary && pend_q) begin
         div_act_d  = div_sh_q;
         high_act_d = high_sh_q;
         pend_d     = 1'b0;
      end

      if (cfg_load) begin
         div_sh_d  = (div_in < MinDiv) ? MinDiv : div_in;
         high_sh_d = high_in;
         pend_d    = 1'b1;
      end

      if (enable) begin
         clk_d  = (cnt_d < high_act_d);
         tick_d = (cnt_d == '0);
      end
   end

   assign clk_out     = clk_q;
   assign tick        = tick_q;
   assign cfg_pending = pend_q;

endmodule
